// File: rtl/rv_hazard_pkg.sv
// Shared types and helpers for the pipeline hazard/control unit.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package rv_hazard_pkg;

    // Control FSM states: post-reset flush, normal run, multi-cycle load-use bubble, halted.
    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_RUN    = 2'd1,
        ST_LSTALL = 2'd2,
        ST_HALT   = 2'd3
    } ctrl_state_t;

    // Bypass select value meaning "take the operand from the register file".
    localparam int BP_DIRECT = 0;

    // Width of a bypass select able to encode 0 (regfile) plus one code per forwarding stage.
    function automatic int bp_idx(input int fwd_stages);
        return (fwd_stages < 1) ? 1 : $clog2(fwd_stages + 1);
    endfunction

endpackage

// File: rtl/rv_hazard_unit_fwd_sel.sv
// Priority matcher choosing which forwarding stage supplies one exec operand.
// Latency: purely combinational, zero cycles.
// Backpressure: none; select follows the inputs every cycle.
module rv_fwd_sel
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int BP_W       = bp_idx(FWD_STAGES)
) (
    input  logic [REG_AW-1:0]            rs_i,
    input  logic [FWD_STAGES*REG_AW-1:0] rd_vec_i,
    input  logic [FWD_STAGES-1:0]        we_i,
    output logic [BP_W-1:0]              sel_o
);

    // Scan oldest to youngest so the youngest matching stage wins; x0 never bypasses.
    always_comb begin
        sel_o = BP_W'(BP_DIRECT);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (we_i[k] && (rs_i != '0) && (rs_i == rd_vec_i[k*REG_AW +: REG_AW])) begin
                sel_o = BP_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/rv_hazard_unit.sv
// Hazard/control unit: operand bypass selects plus stall/flush enables for fetch/decode/exec/memory.
// Latency: stall/flush/bypass are combinational on state and inputs; halt is visible one cycle after detection.
// Backpressure: a data-bus wait freezes every stage and the FSM; load-use and fetch waits hold fetch/decode.
module rv_hazard_unit
    import rv_hazard_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int FWD_STAGES      = 3,
    parameter int LOAD_USE_CYC    = 1,
    parameter int RESET_FLUSH_CYC = 2
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_fetch_bus_ack,
    input  logic                           i_mem_req,
    input  logic                           i_mem_ack,
    input  logic [REG_AW-1:0]              i_decode_rs1,
    input  logic [REG_AW-1:0]              i_decode_rs2,
    input  logic                           i_decode_inv_instr,
    input  logic [REG_AW-1:0]              i_exec_rs1,
    input  logic [REG_AW-1:0]              i_exec_rs2,
    input  logic [REG_AW-1:0]              i_exec_rd,
    input  logic                           i_exec_is_load,
    input  logic                           i_exec_pc_sel,
    input  logic [FWD_STAGES*REG_AW-1:0]   i_fwd_rd,
    input  logic [FWD_STAGES-1:0]          i_fwd_we,
    output logic [bp_idx(FWD_STAGES)-1:0]  o_exec_bp_rs1,
    output logic [bp_idx(FWD_STAGES)-1:0]  o_exec_bp_rs2,
    output logic                           o_fetch_stall,
    output logic                           o_decode_stall,
    output logic                           o_exec_stall,
    output logic                           o_memory_stall,
    output logic                           o_decode_flush,
    output logic                           o_exec_flush,
    output logic                           o_halted
);

    localparam int BP_W    = bp_idx(FWD_STAGES);
    localparam int CNT_MAX = (LOAD_USE_CYC > RESET_FLUSH_CYC) ? LOAD_USE_CYC : RESET_FLUSH_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RESET_FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LU  = (LOAD_USE_CYC > 1) ? CNT_W'(LOAD_USE_CYC - 2) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ctrl_state_t      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             halted_q;

    logic is_reset;
    logic is_halt;
    logic is_lstall;
    logic run_like;
    logic memwait;
    logic redirect;
    logic dec_flush_hi;
    logic illegal;
    logic lu_hit;
    logic load_use;
    logic fetch_wait;

    // One matcher per exec operand; selects are independent of FSM state.
    rv_fwd_sel #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .BP_W       (BP_W)
    ) u_fwd_rs1 (
        .rs_i     (i_exec_rs1),
        .rd_vec_i (i_fwd_rd),
        .we_i     (i_fwd_we),
        .sel_o    (o_exec_bp_rs1)
    );

    rv_fwd_sel #(
        .REG_AW     (REG_AW),
        .FWD_STAGES (FWD_STAGES),
        .BP_W       (BP_W)
    ) u_fwd_rs2 (
        .rs_i     (i_exec_rs2),
        .rd_vec_i (i_fwd_rd),
        .we_i     (i_fwd_we),
        .sel_o    (o_exec_bp_rs2)
    );

    // Resolve which hazard owns this cycle; each term is masked by every higher-priority one.
    always_comb begin
        is_reset     = (state_q == ST_RESET);
        is_halt      = (state_q == ST_HALT);
        is_lstall    = (state_q == ST_LSTALL);
        run_like     = (state_q == ST_RUN) || is_lstall;
        lu_hit       = i_exec_is_load && (i_exec_rd != '0) &&
                       ((i_exec_rd == i_decode_rs1) || (i_exec_rd == i_decode_rs2));
        memwait      = run_like && i_mem_req && !i_mem_ack;
        redirect     = run_like && !memwait && i_exec_pc_sel;
        // Decode flush can only come from a redirect at this point, so an illegal
        // instruction is honoured only when it is not being squashed.
        dec_flush_hi = redirect;
        illegal      = run_like && !memwait && i_decode_inv_instr && !dec_flush_hi;
        load_use     = run_like && !memwait && !redirect && !illegal && (lu_hit || is_lstall);
        fetch_wait   = run_like && !memwait && !redirect && !illegal && !load_use && !i_fetch_bus_ack;
    end

    // Stage enables derived from the winning hazard; no output feeds back into another.
    always_comb begin
        o_fetch_stall  = memwait || load_use || fetch_wait || is_halt;
        o_decode_stall = memwait || load_use || fetch_wait || is_halt;
        o_exec_stall   = memwait;
        o_memory_stall = memwait;
        o_decode_flush = is_reset || is_halt || redirect;
        o_exec_flush   = is_reset || is_halt || redirect || illegal || load_use || fetch_wait;
        o_halted       = halted_q;
    end

    // Control FSM: reset flush countdown, load-use bubble countdown, sticky halt.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_RESET;
            cnt_q    <= CNT_RST;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_RUN, ST_LSTALL: begin
                    if (memwait) begin
                        // Everything frozen; a pending redirect is acted on once the bus completes.
                    end else if (redirect) begin
                        // The dependent instruction is squashed, so any bubble sequence is moot.
                        state_q <= ST_RUN;
                    end else if (illegal) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else if (load_use) begin
                        if (is_lstall) begin
                            if (cnt_q == '0) begin
                                state_q <= ST_RUN;
                            end else begin
                                cnt_q <= cnt_q - CNT_ONE;
                            end
                        end else if (LOAD_USE_CYC > 1) begin
                            state_q <= ST_LSTALL;
                            cnt_q   <= CNT_LU;
                        end
                    end
                end
                default: begin
                    // ST_HALT: held until reset.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_hazard_unit.sv
// Directed and randomized checks of rv_hazard_unit against a cycle-level behavioural model.
// Latency: model predicts outputs for the current cycle, updates its bookkeeping after each edge.
// Backpressure: n/a.
module tb_rv_hazard_unit;

    localparam int REG_AW = 5;
    localparam int FWD    = 3;
    localparam int LUC    = 3;
    localparam int RFC    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ack, mem_req, mem_ack;
    logic [4:0]  dec_rs1, dec_rs2, ex_rs1, ex_rs2, ex_rd;
    logic        dec_inv, ex_load, ex_pc_sel;
    logic [14:0] fwd_rd;
    logic [2:0]  fwd_we;
    logic [1:0]  bp1, bp2;
    logic        fs, ds, es, ms, df, ef, halted;

    always #5 clk = ~clk;

    rv_hazard_unit #(
        .REG_AW          (REG_AW),
        .FWD_STAGES      (FWD),
        .LOAD_USE_CYC    (LUC),
        .RESET_FLUSH_CYC (RFC)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_fetch_bus_ack    (fetch_ack),
        .i_mem_req          (mem_req),
        .i_mem_ack          (mem_ack),
        .i_decode_rs1       (dec_rs1),
        .i_decode_rs2       (dec_rs2),
        .i_decode_inv_instr (dec_inv),
        .i_exec_rs1         (ex_rs1),
        .i_exec_rs2         (ex_rs2),
        .i_exec_rd          (ex_rd),
        .i_exec_is_load     (ex_load),
        .i_exec_pc_sel      (ex_pc_sel),
        .i_fwd_rd           (fwd_rd),
        .i_fwd_we           (fwd_we),
        .o_exec_bp_rs1      (bp1),
        .o_exec_bp_rs2      (bp2),
        .o_fetch_stall      (fs),
        .o_decode_stall     (ds),
        .o_exec_stall       (es),
        .o_memory_stall     (ms),
        .o_decode_flush     (df),
        .o_exec_flush       (ef),
        .o_halted           (halted)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model bookkeeping: flush cycles still owed after reset, load-use bubbles still owed, halt flag.
    int m_reset_left, m_lu_left, n_reset_left, n_lu_left;
    bit m_halted, n_halted;
    int e_fs, e_ds, e_es, e_ms, e_df, e_ef, e_h, e_bp1, e_bp2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bypass rule: first (youngest) writing stage whose destination equals a nonzero source.
    function automatic int ref_bp(input logic [4:0] rs);
        logic [4:0] stage_rd [3];
        for (int k = 0; k < FWD; k++) stage_rd[k] = fwd_rd[k*5 +: 5];
        if (rs == 5'd0) return 0;
        for (int k = 0; k < FWD; k++) if (fwd_we[k] && stage_rd[k] == rs) return k + 1;
        return 0;
    endfunction

    task automatic model_eval();
        bit hit;
        e_fs = 0; e_ds = 0; e_es = 0; e_ms = 0; e_df = 0; e_ef = 0;
        n_reset_left = m_reset_left; n_lu_left = m_lu_left; n_halted = m_halted;
        e_bp1 = ref_bp(ex_rs1);
        e_bp2 = ref_bp(ex_rs2);
        e_h   = m_halted ? 1 : 0;
        hit   = ex_load && ex_rd != 0 && (ex_rd == dec_rs1 || ex_rd == dec_rs2);
        if (!rst_n) begin
            e_df = 1; e_ef = 1; e_h = 0;
            n_reset_left = RFC; n_lu_left = 0; n_halted = 0;
        end else if (m_reset_left > 0) begin
            e_df = 1; e_ef = 1;
            n_reset_left = m_reset_left - 1;
        end else if (m_halted) begin
            e_fs = 1; e_ds = 1; e_df = 1; e_ef = 1;
        end else if (mem_req && !mem_ack) begin
            e_fs = 1; e_ds = 1; e_es = 1; e_ms = 1;
        end else if (ex_pc_sel) begin
            e_df = 1; e_ef = 1; n_lu_left = 0;
        end else if (dec_inv) begin
            e_ef = 1; n_halted = 1;
        end else if (m_lu_left > 0 || hit) begin
            e_fs = 1; e_ds = 1; e_ef = 1;
            n_lu_left = (m_lu_left > 0) ? m_lu_left - 1 : LUC - 1;
        end else if (!fetch_ack) begin
            e_fs = 1; e_ds = 1; e_ef = 1;
        end
    endtask

    // Sample on the falling edge and compare every output with the model.
    task automatic settle();
        @(negedge clk);
        model_eval();
        chk("bp_rs1", 32'(bp1), e_bp1);
        chk("bp_rs2", 32'(bp2), e_bp2);
        chk("fetch_stall", 32'(fs), e_fs);
        chk("decode_stall", 32'(ds), e_ds);
        chk("exec_stall", 32'(es), e_es);
        chk("memory_stall", 32'(ms), e_ms);
        chk("decode_flush", 32'(df), e_df);
        chk("exec_flush", 32'(ef), e_ef);
        chk("halted", 32'(halted), e_h);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_reset_left = n_reset_left;
        m_lu_left    = n_lu_left;
        m_halted     = n_halted;
    endtask

    task automatic clear_inputs();
        fetch_ack = 1'b1; mem_req = 1'b0; mem_ack = 1'b0;
        dec_rs1 = '0; dec_rs2 = '0; dec_inv = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_load = 1'b0; ex_pc_sel = 1'b0;
        fwd_rd = '0; fwd_we = '0;
    endtask

    initial begin
        m_reset_left = RFC; m_lu_left = 0; m_halted = 0;
        rst_n = 1'b0;
        clear_inputs();

        // Reset held, then released: exactly two flush cycles follow.
        settle(); chk("rst_decode_flush", 32'(df), 1); chk("rst_fetch_stall", 32'(fs), 0);
        tick();
        settle(); tick();
        rst_n = 1'b1;
        settle(); chk("rel_flush_c1", 32'(df), 1); tick();
        settle(); chk("rel_flush_c2", 32'(ef), 1); tick();
        settle(); chk("rel_flush_c3", 32'(df), 0); chk("rel_stall_c3", 32'(fs), 0); tick();

        // Bypass priority and x0 exclusion.
        ex_rs1 = 5'd5; fwd_rd = {5'd5, 5'd5, 5'd5}; fwd_we = 3'b110;
        settle(); chk("bp_youngest_valid", 32'(bp1), 2); tick();
        ex_rs1 = 5'd0; fwd_rd = {5'd0, 5'd0, 5'd0}; fwd_we = 3'b111;
        settle(); chk("bp_x0", 32'(bp1), 0); tick();
        ex_rs2 = 5'd9; fwd_rd = {5'd9, 5'd3, 5'd4};
        settle(); chk("bp_oldest", 32'(bp2), 3); tick();
        clear_inputs();

        // Load-use with three bubble cycles.
        ex_load = 1'b1; ex_rd = 5'd7; dec_rs2 = 5'd7;
        settle(); chk("lu_c1_fs", 32'(fs), 1); chk("lu_c1_ef", 32'(ef), 1); tick();
        ex_load = 1'b0;
        settle(); chk("lu_c2_fs", 32'(fs), 1); tick();
        settle(); chk("lu_c3_ds", 32'(ds), 1); tick();
        settle(); chk("lu_done_fs", 32'(fs), 0); chk("lu_done_ef", 32'(ef), 0); tick();

        // Redirect on the second bubble cycle aborts the sequence.
        ex_load = 1'b1;
        settle(); tick();
        ex_load = 1'b0; ex_pc_sel = 1'b1;
        settle(); chk("rd_df", 32'(df), 1); chk("rd_fs", 32'(fs), 0); tick();
        ex_pc_sel = 1'b0;
        settle(); chk("rd_run_fs", 32'(fs), 0); tick();

        // Data-bus wait masks a pending redirect until the ack.
        mem_req = 1'b1; mem_ack = 1'b0; ex_pc_sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle(); chk("mw_ms", 32'(ms), 1); chk("mw_df", 32'(df), 0); tick();
        end
        mem_ack = 1'b1;
        settle(); chk("mw_ack_df", 32'(df), 1); chk("mw_ack_es", 32'(es), 0); tick();
        clear_inputs();

        // Instruction fetch not returning data.
        fetch_ack = 1'b0;
        settle(); chk("fw_fs", 32'(fs), 1); tick();
        fetch_ack = 1'b1;

        // Illegal instruction: sticky halt, cleared only by async reset.
        dec_inv = 1'b1;
        settle(); chk("il_ef", 32'(ef), 1); chk("il_not_yet", 32'(halted), 0); tick();
        dec_inv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle(); chk("il_halted", 32'(halted), 1); tick();
        end
        rst_n = 1'b0;
        #1;
        chk("il_async_clear", 32'(halted), 0);
        settle(); tick();
        rst_n = 1'b1;
        settle(); tick();
        settle(); tick();

        // Randomized traffic against the model, with resets to escape halts.
        for (int c = 0; c < 600; c++) begin
            if (m_halted && $urandom_range(0, 3) == 0) begin
                rst_n = 1'b0;
                clear_inputs();
                settle(); tick();
                rst_n = 1'b1;
            end else begin
                fetch_ack = ($urandom_range(0, 5) != 0);
                mem_req   = ($urandom_range(0, 2) == 0);
                mem_ack   = 1'($urandom);
                ex_pc_sel = ($urandom_range(0, 7) == 0);
                dec_inv   = ($urandom_range(0, 49) == 0);
                ex_load   = 1'($urandom);
                ex_rd     = 5'($urandom_range(0, 3));
                dec_rs1   = 5'($urandom_range(0, 3));
                dec_rs2   = 5'($urandom_range(0, 3));
                ex_rs1    = 5'($urandom_range(0, 3));
                ex_rs2    = 5'($urandom_range(0, 3));
                fwd_rd    = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
                fwd_we    = 3'($urandom);
                settle(); tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
